instruction_fetch_unit: RTL and testbench

- Instruction-side counterpart of the multicycle RISC Controller.
- Owns the PC and the instruction register (IR).
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and presents InsM = IR[15:8] and InsL = IR[1:0] to the Controller.
- Computes and commits the next PC when the Controller strobes Buff_PC, using the Controller's Branch, Flag and Jump outputs.

---
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over req/ack,
// and commits the Controller-selected next PC at end of instruction.
module instruction_fetch_unit #(
   parameter int unsigned ADDR_W = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              Rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_ack,
   output logic [7:0]        InsM,
   output logic [1:0]        InsL,
   output logic              Ins_Valid,
   input  logic              Buff_PC,
   input  logic              Branch,
   input  logic              Flag,
   input  logic [1:0]        Jump,
   input  logic [ADDR_W-1:0] RegTarget,
   input  logic              Done,
   output logic [ADDR_W-1:0] PCplus1,
   output logic              Halted
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] jp_off;
   logic [ADDR_W-1:0] next_pc;

   assign pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign br_off = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
   assign jp_off = {{(ADDR_W-11){ir[10]}}, ir[10:0]};

   // Branch outranks Jump; reserved Jump code falls through to PC+1
   always_comb begin
      next_pc = pc_inc;
      if (Branch) begin
         if (Flag) next_pc = pc_inc + br_off;
      end else if (Jump == 2'b01) begin
         next_pc = pc_inc + jp_off;
      end else if (Jump == 2'b10) begin
         next_pc = RegTarget;
      end
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         ir        <= 16'h0000;
         imem_req  <= 1'b0;
         Ins_Valid <= 1'b0;
         Halted    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               // ack only counts against an outstanding request
               if (imem_req && imem_ack) begin
                  ir        <= imem_rdata;
                  imem_req  <= 1'b0;
                  Ins_Valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            HOLD: begin
               if (Done) begin
                  Halted <= 1'b1;
                  state  <= HALT;
               end else if (Buff_PC) begin
                  pc        <= next_pc;
                  Ins_Valid <= 1'b0;
                  state     <= FETCH;
               end
            end
            HALT: state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_addr = pc;
   assign PCplus1   = pc_inc;
   assign InsM      = ir[15:8];
   assign InsL      = ir[1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table of control vectors plus
// hand-written halt, stray-ack and mid-fetch reset sequences.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        Rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ack;
   logic [7:0]  InsM;
   logic [1:0]  InsL;
   logic        Ins_Valid;
   logic        Buff_PC;
   logic        Branch;
   logic        Flag;
   logic [1:0]  Jump;
   logic [15:0] RegTarget;
   logic        Done;
   logic [15:0] PCplus1;
   logic        Halted;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .Rst(Rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .InsM(InsM), .InsL(InsL), .Ins_Valid(Ins_Valid),
      .Buff_PC(Buff_PC), .Branch(Branch), .Flag(Flag),
      .Jump(Jump), .RegTarget(RegTarget), .Done(Done),
      .PCplus1(PCplus1), .Halted(Halted)
   );

   typedef struct {
      logic [15:0] ir;
      logic        br;
      logic        fl;
      logic [1:0]  jmp;
      logic [15:0] rt;
      logic [15:0] nxt;
   } vec_t;

   vec_t        vec [16];
   logic [15:0] addr_q [$];
   logic [15:0] cur_pc;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait for a request, score its address, then ack after lat cycles
   task automatic serve(input logic [15:0] word, input int lat);
      int n = 0;
      logic [15:0] exp;
      while (!imem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) begin
         check("req_timeout", 32'(imem_req), 32'd1);
         return;
      end
      exp = (addr_q.size() > 0) ? addr_q.pop_front() : 16'hxxxx;
      cur_pc = exp;
      check("fetch_addr", 32'(imem_addr), 32'(exp));
      repeat (lat) @(negedge clk);
      check("req_held", 32'(imem_req), 32'd1);
      imem_rdata = word;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 16'($urandom);
      check("valid_after_ack", 32'(Ins_Valid), 32'd1);
      check("req_after_ack", 32'(imem_req), 32'd0);
      check("insm", 32'(InsM), 32'(word[15:8]));
      check("insl", 32'(InsL), 32'(word[1:0]));
      check("pcplus1", 32'(PCplus1), 32'(16'(cur_pc + 16'd1)));
   endtask

   initial begin
      vec[0]  = '{16'h0800, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0001};
      vec[1]  = '{16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0002};
      vec[2]  = '{16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0003};
      vec[3]  = '{16'h0000, 1'b0, 1'b0, 2'b10, 16'h0010, 16'h0010};
      vec[4]  = '{16'hC3FC, 1'b1, 1'b1, 2'b00, 16'h0000, 16'h000D};
      vec[5]  = '{16'h0000, 1'b0, 1'b0, 2'b10, 16'h0010, 16'h0010};
      vec[6]  = '{16'hC3FC, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0011};
      vec[7]  = '{16'h0000, 1'b0, 1'b0, 2'b10, 16'h0020, 16'h0020};
      vec[8]  = '{16'h8005, 1'b0, 1'b0, 2'b01, 16'h0000, 16'h0026};
      vec[9]  = '{16'h8005, 1'b1, 1'b0, 2'b01, 16'h0000, 16'h0027};
      vec[10] = '{16'h0000, 1'b0, 1'b0, 2'b10, 16'h1234, 16'h1234};
      vec[11] = '{16'h0000, 1'b0, 1'b0, 2'b11, 16'hBEEF, 16'h1235};
      vec[12] = '{16'h0000, 1'b0, 1'b0, 2'b10, 16'hFFFF, 16'hFFFF};
      vec[13] = '{16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000};
      vec[14] = '{16'h0400, 1'b0, 1'b0, 2'b01, 16'h0000, 16'hFC01};
      vec[15] = '{16'h0000, 1'b0, 1'b0, 2'b10, 16'h0005, 16'h0005};

      Rst = 1'b0;
      imem_rdata = 16'h0;
      imem_ack = 1'b0;
      Buff_PC = 1'b0;
      Branch = 1'b0;
      Flag = 1'b0;
      Jump = 2'b00;
      RegTarget = 16'h0;
      Done = 1'b0;
      cur_pc = 16'h0;
      repeat (3) @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(Ins_Valid), 32'd0);
      check("rst_halted", 32'(Halted), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'h0);
      check("rst_insm", 32'(InsM), 32'h0);

      Rst = 1'b1;
      @(negedge clk);
      check("idle_to_fetch_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      check("first_req", 32'(imem_req), 32'd1);
      addr_q.push_back(16'h0000);

      for (int i = 0; i < 16; i++) begin
         serve(vec[i].ir, (i == 0) ? 3 : i % 4);
         Branch = vec[i].br;
         Flag = vec[i].fl;
         Jump = vec[i].jmp;
         RegTarget = vec[i].rt;
         Buff_PC = 1'b1;
         addr_q.push_back(vec[i].nxt);
         @(negedge clk);
         Buff_PC = 1'b0;
         Branch = 1'b0;
         Flag = 1'b0;
         Jump = 2'b00;
         check("valid_drop", 32'(Ins_Valid), 32'd0);
         check("req_low_after_commit", 32'(imem_req), 32'd0);
      end

      serve(16'hABCD, 1);
      Done = 1'b1;
      Buff_PC = 1'b1;
      Jump = 2'b10;
      RegTarget = 16'h4444;
      @(negedge clk);
      Done = 1'b0;
      Buff_PC = 1'b0;
      Jump = 2'b00;
      check("halted", 32'(Halted), 32'd1);
      check("halt_pc", 32'(imem_addr), 32'h0005);
      check("halt_valid", 32'(Ins_Valid), 32'd1);
      for (int k = 0; k < 4; k++) begin
         imem_ack = (k == 1);
         imem_rdata = 16'h1357;
         Buff_PC = (k == 2);
         @(negedge clk);
         check("halt_no_req", 32'(imem_req), 32'd0);
      end
      imem_ack = 1'b0;
      Buff_PC = 1'b0;
      check("stray_ack_insm", 32'(InsM), 32'hAB);
      check("stray_ack_insl", 32'(InsL), 32'h1);
      check("halt_pc_held", 32'(imem_addr), 32'h0005);
      check("still_halted", 32'(Halted), 32'd1);

      Rst = 1'b0;
      @(negedge clk);
      check("rst_unhalt", 32'(Halted), 32'd0);
      Rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("refetch_req", 32'(imem_req), 32'd1);
      check("refetch_addr", 32'(imem_addr), 32'h0000);
      #2 Rst = 1'b0;
      #1;
      check("midfetch_req", 32'(imem_req), 32'd0);
      check("midfetch_pc", 32'(imem_addr), 32'h0000);
      check("midfetch_valid", 32'(Ins_Valid), 32'd0);
      @(negedge clk);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      check("rst_ack_discard", 32'(Ins_Valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
